// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF layer sequencer: FSM states,
// datapath widths and the saturation bounds of the membrane potential.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int V_W   = 8;
  localparam int UPD_W = 10;

  localparam logic signed [UPD_W-1:0] V_MAX = 10'sd127;
  localparam logic signed [UPD_W-1:0] V_MIN = -10'sd128;

  function automatic logic signed [UPD_W-1:0] sext_upd(input logic signed [V_W-1:0] x);
    return {{(UPD_W-V_W){x[V_W-1]}}, x};
  endfunction

endpackage

// File: rtl/lif_layer_sequencer_if.sv
// Timestep request/response bundle between the timestep controller (master)
// and the LIF layer sequencer (slave).
interface lif_layer_sequencer_if #(
  parameter int N_NEURONS = 4
);
  import lif_pkg::*;

  // step_start is a single-cycle request, accepted only when the sequencer is
  // idle; step_busy covers the run, step_done pulses once per accepted request
  // and spike_vec is valid from that pulse until the next one.
  logic                   step_start;
  logic [8*N_NEURONS-1:0] input_current;
  logic [7:0]             threshold;
  logic [7:0]             decay;
  logic [7:0]             refractory_period;
  logic                   step_busy;
  logic                   step_done;
  logic [N_NEURONS-1:0]   spike_vec;
  logic                   overrun;
  state_t                 dbg_state;

  modport master (
    output step_start, input_current, threshold, decay, refractory_period,
    input  step_busy, step_done, spike_vec, overrun, dbg_state
  );

  modport slave (
    input  step_start, input_current, threshold, decay, refractory_period,
    output step_busy, step_done, spike_vec, overrun, dbg_state
  );

endinterface

// File: rtl/lif_update_core.sv
// Combinational single-neuron leaky-integrate-and-fire update: refractory
// countdown, threshold fire with subtractive reset, or saturating integrate.
module lif_update_core
  import lif_pkg::*;
(
  input  logic signed [V_W-1:0] v_i,
  input  logic        [V_W-1:0] r_i,
  input  logic signed [V_W-1:0] cur_i,
  input  logic signed [V_W-1:0] thr_i,
  input  logic signed [V_W-1:0] decay_i,
  input  logic        [V_W-1:0] refr_i,
  output logic signed [V_W-1:0] v_d_o,
  output logic        [V_W-1:0] r_d_o,
  output logic                  spike_o
);

  logic signed [UPD_W-1:0] leak;
  logic signed [UPD_W-1:0] sum;

  always_comb begin
    // Leak pulls the potential toward zero from either side.
    leak    = v_i[V_W-1] ? sext_upd(decay_i) : -sext_upd(decay_i);
    sum     = sext_upd(v_i) + sext_upd(cur_i) + leak;
    v_d_o   = v_i;
    r_d_o   = r_i;
    spike_o = 1'b0;
    if (r_i != '0) begin
      r_d_o = r_i - 8'd1;
    end else if (v_i >= thr_i) begin
      spike_o = 1'b1;
      v_d_o   = v_i - thr_i;
      r_d_o   = refr_i;
    end else if (sum > V_MAX) begin
      v_d_o = V_MAX[V_W-1:0];
    end else if (sum < V_MIN) begin
      v_d_o = V_MIN[V_W-1:0];
    end else begin
      v_d_o = sum[V_W-1:0];
    end
  end

endmodule

// File: rtl/lif_layer_sequencer.sv
// Time-multiplexed LIF layer: one shared update core walks N_NEURONS neurons,
// one per cycle, per timestep. Optional sticky overrun flag: LIF_SEQ_OVERRUN_EN.
module lif_layer_sequencer
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input logic                  clk,
  input logic                  reset,
  lif_layer_sequencer_if.slave bus
);

  state_t                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic signed [V_W-1:0]     v_q   [N_NEURONS];
  logic        [V_W-1:0]     r_q   [N_NEURONS];
  logic signed [V_W-1:0]     cur_q [N_NEURONS];
  logic signed [V_W-1:0]     thr_q;
  logic signed [V_W-1:0]     dec_q;
  logic        [V_W-1:0]     refr_q;
  logic [N_NEURONS-1:0]      stage_q;
  logic [N_NEURONS-1:0]      spike_vec_q;
  logic                      busy_q;
  logic                      done_q;

  logic signed [V_W-1:0]     v_d;
  logic        [V_W-1:0]     r_d;
  logic                      spike_d;

  lif_update_core u_core (
    .v_i     (v_q[idx_q]),
    .r_i     (r_q[idx_q]),
    .cur_i   (cur_q[idx_q]),
    .thr_i   (thr_q),
    .decay_i (dec_q),
    .refr_i  (refr_q),
    .v_d_o   (v_d),
    .r_d_o   (r_d),
    .spike_o (spike_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      thr_q       <= '0;
      dec_q       <= '0;
      refr_q      <= '0;
      stage_q     <= '0;
      spike_vec_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k]   <= '0;
        r_q[k]   <= '0;
        cur_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (bus.step_start) begin
            // Shadow copies make the whole step immune to input changes.
            for (int k = 0; k < N_NEURONS; k++) begin
              cur_q[k] <= bus.input_current[8*k +: 8];
            end
            thr_q   <= bus.threshold;
            dec_q   <= bus.decay;
            refr_q  <= bus.refractory_period;
            idx_q   <= '0;
            stage_q <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          busy_q         <= 1'b1;
          v_q[idx_q]     <= v_d;
          r_q[idx_q]     <= r_d;
          stage_q[idx_q] <= spike_d;
          if (idx_q == IDX_W'(N_NEURONS - 1)) begin
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          busy_q      <= 1'b1;
          done_q      <= 1'b1;
          spike_vec_q <= stage_q;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef LIF_SEQ_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (bus.step_start && (state_q != ST_IDLE)) begin
      overrun_q <= 1'b1;
    end
  end

  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.step_busy = busy_q;
  assign bus.step_done = done_q;
  assign bus.spike_vec = spike_vec_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/lif_layer_sequencer.md
Name: lif_layer_sequencer

Overview:
Time-multiplexes one shared leaky-integrate-and-fire update datapath across N_NEURONS virtual neurons. Per-neuron state (membrane potential, refractory counter) lives in internal register arrays. One network timestep is triggered by a start pulse. The block then walks the neurons one per cycle and presents the layer spike vector with a done pulse. It sits between the timestep controller and the spike router.

Parameters:
N_NEURONS, 4, number of virtual neurons sequenced per timestep (>=2)
IDX_W, $clog2(N_NEURONS), width of neuron index counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous reset, active-high
step_start  in  1  1-cycle request to run one timestep
input_current  in  8*N_NEURONS  per-neuron signed current; neuron k at bits [8k+7:8k]
threshold  in  8  signed firing threshold, shared
decay  in  8  signed leak magnitude, shared
refractory_period  in  8  unsigned refractory cycles (timesteps), shared
step_busy  out  1  high from cycle after accepted start until done cycle inclusive
step_done  out  1  1-cycle pulse, spike_vec valid
spike_vec  out  N_NEURONS  bit k = neuron k fired this timestep
overrun  out  1  sticky start-while-busy flag (see Optional Feature)

Behaviour:
- Reset (any time, mid-step included): all potentials=0, refractory counters=0, spike_vec=0, step_busy=0, step_done=0, overrun=0, FSM->IDLE. An in-flight step is discarded.
- FSM: IDLE -> RUN on step_start. RUN holds idx 0..N_NEURONS-1, one neuron per cycle. RUN -> DONE after idx=N_NEURONS-1. DONE -> IDLE after one cycle.
- On acceptance, capture input_current, threshold, decay and refractory_period into shadow registers. Input changes during RUN have no effect.
- Latency: start sampled at edge t; neuron k updated at edge t+1+k; step_done=1 and spike_vec updated during cycle t+N_NEURONS+1 (after edge t+N_NEURONS+1).
- step_start while not in IDLE (RUN or DONE) is ignored.
- Per-neuron update (v=potential, r=refractory count, all signed except r):
  - if r>0: r<=r-1, v unchanged, spike bit 0.
  - else if v >= threshold (signed compare on pre-update v): spike bit 1, v<=v-threshold (8-bit wrap), r<=refractory_period.
  - else: sum = sext10(v) + sext10(I) + (v[7] ? +sext10(decay) : -sext10(decay)); v<=sat(sum, -128, 127); spike bit 0.
- Spike bits accumulate in a staging register. spike_vec is loaded from staging only on entry to DONE and holds until the next DONE or reset.
- step_done is high exactly one cycle per accepted start.

Optional Feature:
LIF_SEQ_OVERRUN_EN
- Defined: overrun is set when step_start=1 while FSM is not IDLE. It stays set until reset.
- Undefined: overrun tied to 0, no extra logic.

Decomposition:
- Package lif_pkg: FSM state enum (IDLE, RUN, DONE); V_W=8, UPD_W=10; V_MAX=127, V_MIN=-128 saturation constants.
- Sub-module lif_update_core: purely combinational single-neuron update. Inputs are v, r, I, threshold, decay, refractory_period. Outputs are v_next, r_next, spike. The sequencer instantiates it once and muxes state by idx.

Test Plan:
- Reset, N=4, I={10,10,10,10}, thr=100, decay=2, refr=0, one start -> done at start+5 cycles; all potentials 8; spike_vec=0000; busy high 5 cycles.
- Neuron 2 preloaded to v=100 via prior steps (I2=50, thr=100, decay=0), other I=0 -> step where v2>=100 gives spike_vec=0100 and v2=0.
- Saturation: v=120, I=100, decay=1, thr=127 -> v=127, no spike. v=-120, I=-100, decay=1 -> v=-128.
- Refractory: refr=2, neuron fires -> next two steps spike bit 0 and v frozen; third step updates normally.
- step_start pulsed at start+2 (RUN) -> ignored, single step_done. With LIF_SEQ_OVERRUN_EN overrun=1 until reset; without, overrun=0.
- reset asserted at start+3 -> no step_done; all state 0; new start runs cleanly from v=0.
